// File: rtl/ysyx_23060191_lsu.sv
// Load/store unit: one memory transaction per op over a valid/ready data port.
// Aligns and extends load data and reports misaligned or illegal ops without touching memory.
module ysyx_23060191_lsu #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_load_i,
    input  logic                 in_store_i,
    input  logic [2:0]           in_funct3_i,
    input  logic [CPU_WIDTH-1:0] in_addr_i,
    input  logic [CPU_WIDTH-1:0] in_wdata_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_req_wen_o,
    output logic [CPU_WIDTH-1:0] mem_addr_o,
    output logic [CPU_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]           mem_wstrb_o,
    input  logic                 mem_resp_valid_i,
    output logic                 mem_resp_ready_o,
    input  logic [CPU_WIDTH-1:0] mem_rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CPU_WIDTH-1:0] lsu_res_o,
    output logic                 load_en_o,
    output logic                 lsu_err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e               state_q, state_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           lane_q, lane_d;
    logic                 wen_q, wen_d, load_en_q, load_en_d, err_q, err_d;

    logic [1:0]           lane;
    logic                 ld_legal, st_legal, misal, acc_err;
    logic [3:0]           st_strb;
    logic [CPU_WIDTH-1:0] st_wdata, rd_shift, ld_ext;
    logic [15:0]          rd_half;

    // Decode of the op presented in IDLE
    assign lane     = in_addr_i[1:0];
    assign ld_legal = (in_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign st_legal = (in_funct3_i inside {3'b000, 3'b001, 3'b010});
    assign misal    = ((in_funct3_i[1:0] == 2'b01) && lane[0]) ||
                      ((in_funct3_i[1:0] == 2'b10) && (lane != 2'b00));
    assign acc_err  = (in_load_i && in_store_i) ||
                      (in_load_i && (!ld_legal || misal)) ||
                      (in_store_i && (!st_legal || misal));

    always_comb begin
        st_strb  = 4'hF;
        st_wdata = in_wdata_i;
        case (in_funct3_i[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << lane;
                st_wdata = {4{in_wdata_i[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << lane;
                st_wdata = {2{in_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment uses the lane and funct3 captured at accept
    assign rd_shift = mem_rdata_i >> {lane_q, 3'b000};
    assign rd_half  = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wen_d     = wen_q;
        res_d     = res_q;
        load_en_d = load_en_q;
        err_d     = err_q;
        funct3_d  = funct3_q;
        lane_d    = lane_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    addr_d    = {in_addr_i[CPU_WIDTH-1:2], 2'b00};
                    wdata_d   = st_wdata;
                    wstrb_d   = (in_store_i && !acc_err) ? st_strb : 4'h0;
                    wen_d     = in_store_i;
                    res_d     = '0;
                    load_en_d = in_load_i;
                    err_d     = acc_err;
                    funct3_d  = in_funct3_i;
                    lane_d    = lane;
                    state_d   = (!acc_err && (in_load_i || in_store_i)) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (mem_resp_valid_i) begin
                    if (load_en_q) res_d = ld_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            wen_q     <= 1'b0;
            res_q     <= '0;
            load_en_q <= 1'b0;
            err_q     <= 1'b0;
            funct3_q  <= 3'd0;
            lane_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wen_q     <= wen_d;
            res_q     <= res_d;
            load_en_q <= load_en_d;
            err_q     <= err_d;
            funct3_q  <= funct3_d;
            lane_q    <= lane_d;
        end
    end

    assign in_ready_o       = (state_q == IDLE);
    assign mem_req_valid_o  = (state_q == REQ);
    assign mem_resp_ready_o = (state_q == RESP);
    assign out_valid_o      = (state_q == DONE);
    assign mem_req_wen_o    = wen_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wstrb_o      = wstrb_q;
    assign lsu_res_o        = res_q;
    assign load_en_o        = load_en_q;
    assign lsu_err_o        = err_q;
endmodule
